mul_result_streamer: RTL and testbench
======================================

# mul_result_streamer

Downstream stage of the 1024×1024-bit parallel multiplier. Captures one 2048-bit product when the multiplier presents it and streams it out as 64 32-bit words, least-significant word first, over a valid/ready interface toward the AXI-Lite register file or a DMA. It accepts one product at a time and reports products offered while it is still streaming.

## Interface

Parameters:
- DATA_WIDTH, 32, output word width
- PROD_WIDTH, 2048, product width; must be a multiple of DATA_WIDTH
- NWORDS, PROD_WIDTH/DATA_WIDTH (64), words per product (derived)

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- prod_in  in  PROD_WIDTH  product from the multiplier's Out
- prod_valid  in  1  product on prod_in is valid this cycle
- prod_ready  out  1  block is idle and will capture on prod_valid
- m_data  out  DATA_WIDTH  current output word
- m_valid  out  1  m_data is valid
- m_ready  in  1  consumer accepts m_data
- m_last  out  1  current word is word NWORDS-1
- m_index  out  $clog2(NWORDS)  index of the current word, 0..NWORDS-1
- busy  out  1  high in SEND
- drop  out  1  sticky: a product was offered while busy
- clear_drop  in  1  synchronous clear of drop

## Operation

- FSM states: IDLE and SEND.
- In IDLE:
  - prod_ready=1, which is decoded combinationally from the state.
  - When prod_valid=1, load prod_in into a PROD_WIDTH shift register, set the index to 0 and go to SEND.
- In SEND:
  - m_valid=1; m_data = shift register[DATA_WIDTH-1:0]; m_index = index; m_last = (index==NWORDS-1).
  - On handshake (m_valid & m_ready) with index<NWORDS-1: shift the register right by DATA_WIDTH (zero-fill) and increment the index.
  - On handshake with index==NWORDS-1: go to IDLE and set the index to 0.
  - With no handshake, all outputs hold stable. m_valid never drops before the handshake.
- prod_valid in SEND:
  - The product is ignored and drop is set to 1.
  - The stream in progress is unaffected.
- drop:
  - Cleared by clear_drop.
  - If set and clear happen in the same cycle, set wins.
- Word order: word k = prod_in[k*DATA_WIDTH +: DATA_WIDTH] as captured.
- No arithmetic is performed on the data; the index is a $clog2(NWORDS)-bit counter and never wraps past NWORDS-1.
- Reset values:
  - state=IDLE, shift register=0, index=0.
  - m_valid=0, m_data=0, m_last=0, m_index=0.
  - busy=0, drop=0, prod_ready=1.

## Timing

- Capture edge T (prod_valid & prod_ready): m_valid=1 with word 0 from T+1.
- With m_ready held high, word k is presented in cycle T+1+k and the last word in T+NWORDS (T+64).
- Back-to-back products:
  - The last handshake at edge L returns the FSM to IDLE, so prod_ready=1 in cycle L+1.
  - The next capture is at the earliest edge L+1, so the minimum period is NWORDS+1 cycles per product.
- Stalls: each cycle of m_ready=0 in SEND adds exactly one cycle; there is no bubble after m_ready returns to 1.
- Reset mid-stream: an asynchronous assertion forces all reset values immediately. The partial stream is discarded and not resumed. After rstn deasserts, the block is ready in the first cycle.
- drop is visible in the cycle after the offending prod_valid.

## Structure

- Shared package mul_pkg holds:
  - DATA_WIDTH=32, OPER_WIDTH=1024, PROD_WIDTH=2048, NWORDS=64.
  - The state enum {IDLE, SEND}.
- These are shared with the multiplier and the operand loader.
- Single module; no sub-module is warranted. The shift register, counter and FSM stay in one always_ff plus combinational output decode.

## Test plan

- Reset: hold rstn=0 → m_valid=0, m_data=0, busy=0, drop=0, prod_ready=1. Release → the idle state persists.
- Product 1 (as from 1×1), m_ready=1 → capture at T. Word 0 = 0x00000001 at T+1, words 1..63 = 0. m_last=1 only at T+64. busy falls after T+64.
- Product with word k = 0xA5000000+k, m_ready toggling 1/0 each cycle → 64 words in order k=0..63. m_data, m_index and m_last are stable during every stall. The stream completes in 127 cycles after capture.
- prod_valid pulsed at word 20 of a stream → the stream is unchanged and drop=1 the next cycle. clear_drop=1 one cycle → drop=0. clear_drop together with a new offense → drop stays 1.
- Two products offered continuously (prod_valid held high), m_ready=1 → the second product is captured the cycle after the first stream's last handshake. Its word 0 appears 66 cycles after the first capture. drop=1 from the continuous offering during SEND.
- rstn pulsed low at word 10 → m_valid drops asynchronously and the index resets. A new product then streams from word 0 correctly.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the 1024x1024 multiplier datapath.
// Used by the operand loader, the multiplier core and the result streamer.
package mul_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OPER_WIDTH = 1024;
    localparam int PROD_WIDTH = 2048;
    localparam int NWORDS     = PROD_WIDTH / DATA_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/mul_result_streamer.sv
// Captures one multiplier product and streams it LSW-first as DATA_WIDTH words
// over valid/ready; products offered mid-stream are dropped and flagged.
module mul_result_streamer #(
    parameter int DATA_WIDTH = mul_pkg::DATA_WIDTH,
    parameter int PROD_WIDTH = mul_pkg::PROD_WIDTH,
    parameter int NWORDS     = PROD_WIDTH / DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [PROD_WIDTH-1:0]     prod_in,
    input  logic                      prod_valid,
    output logic                      prod_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic [$clog2(NWORDS)-1:0] m_index,
    output logic                      busy,
    output logic                      drop,
    input  logic                      clear_drop
);

    import mul_pkg::*;

    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    state_e                state_q, state_d;
    logic [PROD_WIDTH-1:0] sreg_q, sreg_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  drop_q, drop_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            idx_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        drop_d  = drop_q;
        if (clear_drop) drop_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (prod_valid) begin
                    sreg_d  = prod_in;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // An offense in the same cycle as clear_drop keeps the flag set.
                if (prod_valid) drop_d = 1'b1;
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        sreg_d = sreg_q >> DATA_WIDTH;
                        idx_d  = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign prod_ready = (state_q == IDLE);
    assign busy       = (state_q == SEND);
    assign m_valid    = (state_q == SEND);
    assign m_data     = (state_q == SEND) ? sreg_q[DATA_WIDTH-1:0] : '0;
    assign m_index    = idx_q;
    assign m_last     = (state_q == SEND) && (idx_q == LAST_IDX);
    assign drop       = drop_q;

endmodule

// File: tb/tb_mul_result_streamer.sv
// Randomized scoreboard bench for mul_result_streamer.
// A word-level model queues expected words; a monitor compares each presented word.
module tb_mul_result_streamer;

    localparam int DW = 32;
    localparam int PW = 2048;
    localparam int NW = PW / DW;
    localparam int IW = $clog2(NW);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [PW-1:0] prod_in = '0;
    logic          prod_valid = 1'b0;
    logic          prod_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic [IW-1:0] m_index;
    logic          busy;
    logic          drop;
    logic          clear_drop = 1'b0;

    mul_result_streamer dut (
        .clk        (clk),
        .rstn       (rstn),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .m_index    (m_index),
        .busy       (busy),
        .drop       (drop),
        .clear_drop (clear_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            k;
    } exp_t;

    exp_t q[$];
    int   rem = 0;
    bit   mdl_drop = 1'b0;
    int   cycle = 0;
    int   caps = 0;
    int   last_cap = 0;
    int   prev_cap = 0;
    int   checks = 0;
    int   errors = 0;

    bit            seen_valid = 1'b0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] prev_index;
    logic          prev_last;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cycle);
        end
    endtask

    // Reference model: a stream is NW words; one word leaves per accepted beat.
    always @(posedge clk) begin
        cycle++;
        if (rstn) begin
            if (rem == 0) begin
                if (clear_drop) mdl_drop = 1'b0;
                if (prod_valid) begin
                    for (int k = 0; k < NW; k++)
                        q.push_back('{d: prod_in[k*DW +: DW], k: k});
                    rem = NW;
                    caps++;
                    prev_cap = last_cap;
                    last_cap = cycle;
                end
            end else begin
                if (prod_valid) mdl_drop = 1'b1;
                else if (clear_drop) mdl_drop = 1'b0;
                if (m_ready) rem--;
            end
        end
    end

    always @(negedge rstn) begin
        q.delete();
        rem = 0;
        mdl_drop = 1'b0;
        stall_prev = 1'b0;
        seen_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (rstn && seen_valid && m_ready && q.size() > 0)
            void'(q.pop_front());
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("m_valid", 64'(m_valid), 64'(q.size() > 0));
            chk("prod_ready", 64'(prod_ready), 64'(rem == 0));
            chk("busy", 64'(busy), 64'(rem != 0));
            chk("drop", 64'(drop), 64'(mdl_drop));
            if (m_valid && q.size() > 0) begin
                chk("m_data", 64'(m_data), 64'(q[0].d));
                chk("m_index", 64'(m_index), 64'(q[0].k));
                chk("m_last", 64'(m_last), 64'(q[0].k == NW - 1));
            end
            if (stall_prev && m_valid) begin
                chk("stall_data", 64'(m_data), 64'(prev_data));
                chk("stall_index", 64'(m_index), 64'(prev_index));
                chk("stall_last", 64'(m_last), 64'(prev_last));
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_index = m_index;
            prev_last  = m_last;
            seen_valid = m_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_prod();
        for (int k = 0; k < NW; k++) prod_in[k*DW +: DW] = $urandom;
    endtask

    task automatic capture();
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: random ready and random stray offers
    task automatic drain(input int mode);
        int n;
        n = 0;
        while (rem != 0 && n < 2000) begin
            if (mode == 1) begin
                m_ready    = ($urandom_range(0, 3) != 0);
                prod_valid = ($urandom_range(0, 15) == 0);
            end else begin
                m_ready = 1'b1;
            end
            tick();
            n++;
        end
        prod_valid = 1'b0;
        m_ready = 1'b1;
        if (rem != 0) chk("drain_timeout", 64'(rem), 64'd0);
    endtask

    task automatic wait_rem(input int target);
        int n;
        n = 0;
        while (rem != target && n < 500) begin
            tick();
            n++;
        end
        if (rem != target) chk("wait_timeout", 64'(rem), 64'(target));
    endtask

    initial begin
        int n;
        int base;

        repeat (3) tick();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_index", 64'(m_index), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_prod_ready", 64'(prod_ready), 64'd1);
        rstn = 1'b1;
        repeat (2) tick();
        chk("idle_after_rst", 64'(prod_ready), 64'd1);

        // product of 1x1
        prod_in = '0;
        prod_in[0] = 1'b1;
        m_ready = 1'b1;
        capture();
        drain(0);

        // patterned product with alternating ready
        for (int k = 0; k < NW; k++) prod_in[k*DW +: DW] = 32'hA500_0000 + k;
        m_ready = 1'b1;
        capture();
        n = 0;
        while (rem != 0 && n < 400) begin
            tick();
            n++;
            m_ready = ~m_ready;
        end
        chk("toggle_stream_len", 64'(n), 64'd127);
        m_ready = 1'b1;
        tick();

        // offense at word 20, then clear, then clear colliding with offense
        rand_prod();
        capture();
        wait_rem(NW - 20);
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        chk("drop_set", 64'(drop), 64'd1);
        clear_drop = 1'b1;
        tick();
        clear_drop = 1'b0;
        chk("drop_cleared", 64'(drop), 64'd0);
        clear_drop = 1'b1;
        prod_valid = 1'b1;
        tick();
        clear_drop = 1'b0;
        prod_valid = 1'b0;
        chk("drop_set_wins", 64'(drop), 64'd1);
        drain(0);
        clear_drop = 1'b1;
        tick();
        clear_drop = 1'b0;

        // back-to-back products with prod_valid held
        base = caps;
        rand_prod();
        prod_valid = 1'b1;
        tick();
        rand_prod();
        n = 0;
        while (caps < base + 2 && n < 200) begin
            tick();
            n++;
        end
        prod_valid = 1'b0;
        chk("b2b_captures", 64'(caps - base), 64'd2);
        chk("b2b_period", 64'(last_cap - prev_cap), 64'd65);
        chk("b2b_drop", 64'(drop), 64'd1);
        drain(0);
        clear_drop = 1'b1;
        tick();
        clear_drop = 1'b0;

        // asynchronous reset in the middle of a stream
        rand_prod();
        capture();
        wait_rem(NW - 10);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_m_valid", 64'(m_valid), 64'd0);
        chk("arst_m_index", 64'(m_index), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_prod_ready", 64'(prod_ready), 64'd1);
        repeat (2) tick();
        rstn = 1'b1;
        chk("arst_ready_after", 64'(prod_ready), 64'd1);
        rand_prod();
        capture();
        drain(0);

        // randomized products with random backpressure
        for (int i = 0; i < 5; i++) begin
            rand_prod();
            m_ready = $urandom_range(0, 1);
            capture();
            drain(1);
            clear_drop = 1'b1;
            tick();
            clear_drop = 1'b0;
            tick();
        end

        chk("final_queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
